// File: rtl/sysid_check_master_if.sv
// Avalon-MM read-only bus between the sysid checker (master) and the sysid
// control slave.
interface sysid_check_master_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/sysid_check_master.sv
// Boot-time system-ID checker: reads the ID and timestamp words from the sysid
// slave and reports pass, fail or timeout to the boot/reset controller.
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1575711232,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  sysid_check_master_if.master        avm,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout_err,
  output logic [31:0]                 id_value,
  output logic [31:0]                 ts_value
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ID, S_LAT_ID, S_RD_TS, S_LAT_TS, S_CHECK, S_DONE
  } state_e;

  localparam logic [1:0]  LAST_LAT  = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        addr_q, addr_d;
  logic        read_q, read_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        tmo_q, tmo_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [1:0]  lcnt_q, lcnt_d;
  logic        auto_q, auto_d;
  logic        start_go;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    read_d   = read_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    tmo_d    = tmo_q;
    id_d     = id_q;
    ts_d     = ts_q;
    tcnt_d   = tcnt_q;
    lcnt_d   = lcnt_q;
    auto_d   = 1'b0;
    start_go = start | auto_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_go) begin
          state_d = S_RD_ID;
          read_d  = 1'b1;
          addr_d  = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          tmo_d   = 1'b0;
          id_d    = '0;
          ts_d    = '0;
          tcnt_d  = '0;
        end else if (state_q == S_DONE) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end

      S_RD_ID, S_RD_TS: begin
        if (!avm.avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            if (state_q == S_RD_ID) begin
              id_d    = avm.avm_readdata;
              state_d = S_RD_TS;
              addr_d  = 1'b1;
              tcnt_d  = '0;
            end else begin
              ts_d    = avm.avm_readdata;
              state_d = S_CHECK;
              read_d  = 1'b0;
            end
          end else begin
            read_d  = 1'b0;
            lcnt_d  = '0;
            state_d = (state_q == S_RD_ID) ? S_LAT_ID : S_LAT_TS;
          end
        end else begin
          tcnt_d = tcnt_q + 16'd1;
          // Stalled too long: abandon the read; unread words stay zero.
          if (tcnt_d == TMO_LIMIT) begin
            read_d  = 1'b0;
            state_d = S_DONE;
            tmo_d   = 1'b1;
            pass_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      S_LAT_ID: begin
        if (lcnt_q == LAST_LAT) begin
          id_d    = avm.avm_readdata;
          state_d = S_RD_TS;
          read_d  = 1'b1;
          addr_d  = 1'b1;
          tcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_q + 2'd1;
        end
      end

      S_LAT_TS: begin
        if (lcnt_q == LAST_LAT) begin
          ts_d    = avm.avm_readdata;
          state_d = S_CHECK;
        end else begin
          lcnt_d = lcnt_q + 2'd1;
        end
      end

      S_CHECK: begin
        pass_d  = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only; the synchronous
  // reset arms the one-shot auto start so it fires on the first released edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= 1'b0;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      id_q    <= '0;
      ts_q    <= '0;
      tcnt_q  <= '0;
      lcnt_q  <= '0;
      auto_q  <= AUTO_START;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      tcnt_q  <= tcnt_d;
      lcnt_q  <= lcnt_d;
      auto_q  <= auto_d;
    end
  end

  assign avm.avm_address = addr_q;
  assign avm.avm_read    = read_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign timeout_err     = tmo_q;
  assign id_value        = id_q;
  assign ts_value        = ts_q;

endmodule
